// File: rtl/sort4_arbiter.sv
// Two-requester round-robin front end sharing one 4-input sorting network.
// S1 captures the granted batch, S2 captures the sorted batch and drives rsp_*.
module sort_x4 #(
  parameter int DSIZE  = 18,
  parameter int OFFSET = 8
) (
  input  logic [4*DSIZE-1:0] unsorted,
  output logic [4*DSIZE-1:0] sorted
);

  typedef logic [DSIZE-1:0] word_t;

  // Returns {larger, smaller}; ties keep the operand order.
  function automatic logic [2*DSIZE-1:0] cmp_swap(input word_t a, input word_t b);
    if (a[DSIZE-1:OFFSET] > b[DSIZE-1:OFFSET]) begin
      cmp_swap = {a, b};
    end else begin
      cmp_swap = {b, a};
    end
  endfunction

  word_t l0_0_s, l0_1_s, l0_2_s, l0_3_s;
  word_t l1_0_s, l1_1_s, l1_2_s, l1_3_s;
  word_t l2_0_s, l2_1_s, l2_2_s, l2_3_s;
  word_t l3_1_s, l3_2_s;

  assign l0_0_s = unsorted[0*DSIZE +: DSIZE];
  assign l0_1_s = unsorted[1*DSIZE +: DSIZE];
  assign l0_2_s = unsorted[2*DSIZE +: DSIZE];
  assign l0_3_s = unsorted[3*DSIZE +: DSIZE];

  assign {l1_1_s, l1_0_s} = cmp_swap(l0_0_s, l0_1_s);
  assign {l1_3_s, l1_2_s} = cmp_swap(l0_2_s, l0_3_s);
  assign {l2_2_s, l2_0_s} = cmp_swap(l1_0_s, l1_2_s);
  assign {l2_3_s, l2_1_s} = cmp_swap(l1_1_s, l1_3_s);
  assign {l3_2_s, l3_1_s} = cmp_swap(l2_1_s, l2_2_s);

  assign sorted = {l2_3_s, l3_2_s, l3_1_s, l2_0_s};

endmodule

module sort4_arbiter #(
  parameter int DSIZE  = 18,
  parameter int OFFSET = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [4*DSIZE-1:0] req0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [4*DSIZE-1:0] req1_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [4*DSIZE-1:0] rsp_data
);

  logic               s1_valid_r;
  logic               s1_id_r;
  logic [4*DSIZE-1:0] s1_data_r;
  logic               s2_valid_r;
  logic               s2_id_r;
  logic [4*DSIZE-1:0] s2_data_r;
  logic               last_grant_r;

  logic               s2_load_s;
  logic               s1_free_s;
  logic               grant_s;
  logic               accept_s;
  logic [4*DSIZE-1:0] sorted_s;

  sort_x4 #(
    .DSIZE  (DSIZE),
    .OFFSET (OFFSET)
  ) u_sort (
    .unsorted (s1_data_r),
    .sorted   (sorted_s)
  );

  assign s2_load_s = s1_valid_r & (~s2_valid_r | rsp_ready);
  assign s1_free_s = ~s1_valid_r | s2_load_s;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Readys are held low while reset is asserted so nothing is lost in that cycle.
  assign req0_ready = rst_n & s1_free_s & ~grant_s;
  assign req1_ready = rst_n & s1_free_s & grant_s;
  assign accept_s   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Operand stage and grant pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_id_r      <= 1'b0;
      s1_data_r    <= {(4*DSIZE){1'b0}};
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      s1_valid_r   <= 1'b1;
      s1_id_r      <= grant_s;
      s1_data_r    <= grant_s ? req1_data : req0_data;
      last_grant_r <= grant_s;
    end else if (s2_load_s) begin
      s1_valid_r   <= 1'b0;
    end
  end

  // Result stage; holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_id_r    <= 1'b0;
      s2_data_r  <= {(4*DSIZE){1'b0}};
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      s2_id_r    <= s1_id_r;
      s2_data_r  <= sorted_s;
    end else if (s2_valid_r && rsp_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

  assign rsp_valid = s2_valid_r;
  assign rsp_id    = s2_id_r;
  assign rsp_data  = s2_data_r;

endmodule

// File: tb/tb_sort4_arbiter.sv
// Scoreboard bench for sort4_arbiter: accepted batches are queued with their id
// and compared, in order, against each response handshake.
module tb_sort4_arbiter;

  localparam int DSIZE  = 18;
  localparam int OFFSET = 8;
  localparam int W      = 4*DSIZE;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, rsp_ready;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [W-1:0] req0_data, req1_data, rsp_data;

  always #5 clk = ~clk;

  sort4_arbiter #(.DSIZE(DSIZE), .OFFSET(OFFSET)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    int           cyc;
  } sb_t;

  sb_t          sb_q[$];
  int           acc_ids[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           last_latency = 0;
  logic [W-1:0] last_rsp = '0;
  bit           popped   = 1'b0;
  bit           hold_prev = 1'b0;
  logic [W-1:0] hold_data = '0;
  logic         hold_id = 1'b0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Insertion sort by key (full=0) or by the whole word (full=1).
  function automatic logic [W-1:0] sort_lanes(input logic [W-1:0] d, input bit full);
    logic [DSIZE-1:0] w [4];
    logic [DSIZE-1:0] t;
    logic [W-1:0]     r;
    bit               gt;
    for (int i = 0; i < 4; i++) w[i] = d[i*DSIZE +: DSIZE];
    for (int i = 1; i < 4; i++) begin
      for (int j = i; j > 0; j--) begin
        gt = full ? (w[j-1] > w[j]) : (w[j-1][DSIZE-1:OFFSET] > w[j][DSIZE-1:OFFSET]);
        if (gt) begin
          t = w[j]; w[j] = w[j-1]; w[j-1] = t;
        end
      end
    end
    for (int i = 0; i < 4; i++) r[i*DSIZE +: DSIZE] = w[i];
    return r;
  endfunction

  function automatic logic [W-1:0] keys_only(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < 4; i++) r[i*DSIZE +: OFFSET] = {OFFSET{1'b0}};
    return r;
  endfunction

  function automatic logic [W-1:0] rand_batch();
    logic [W-1:0] r;
    for (int i = 0; i < 4; i++) r[i*DSIZE +: DSIZE] = DSIZE'($urandom);
    return r;
  endfunction

  // One clock: sample #1 after the falling edge, then advance to the next falling edge.
  task automatic step();
    sb_t e;
    #1;
    popped = 1'b0;
    if (rst_n) begin
      if (hold_prev) begin
        check_eq("hold_data", rsp_data, hold_data);
        check_eq("hold_id", W'(rsp_id), W'(hold_id));
      end
      if (req0_valid && req0_ready) begin
        sb_q.push_back('{id: 1'b0, data: req0_data, cyc: cyc});
        acc_ids.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back('{id: 1'b1, data: req1_data, cyc: cyc});
        acc_ids.push_back(1);
      end
      if (rsp_valid && rsp_ready) begin
        popped = 1'b1;
        check_eq("rsp_expected", W'(sb_q.size() != 0), W'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("rsp_id", W'(rsp_id), W'(e.id));
          check_eq("rsp_keys", keys_only(rsp_data), keys_only(sort_lanes(e.data, 1'b0)));
          check_eq("rsp_lanes", sort_lanes(rsp_data, 1'b1), sort_lanes(e.data, 1'b1));
          last_latency = cyc - e.cyc;
          last_rsp     = rsp_data;
        end
      end
      hold_prev = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
      hold_id   = rsp_id;
    end else begin
      hold_prev = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_req0_ready", W'(req0_ready), W'(0));
    check_eq("rst_req1_ready", W'(req1_ready), W'(0));
    @(posedge clk);
    cyc++;
    sb_q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    check_eq("rst_rsp_valid", W'(rsp_valid), W'(0));
    check_eq("rst_rsp_data", rsp_data, W'(0));
    check_eq("rst_rsp_id", W'(rsp_id), W'(0));
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    check_eq("drain_empty", W'(sb_q.size()), W'(0));
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    req0_data  = rand_batch();
    req1_data  = rand_batch();

    // Reset with both requesters asserting.
    do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single batch, keys 5,3,9,1.
    acc_ids.delete();
    req0_data  = {18'h00133, 18'h00922, 18'h00311, 18'h00500};
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
    check_eq("single_empty", W'(sb_q.size()), W'(0));
    check_eq("single_latency", W'(last_latency), W'(2));
    check_eq("single_lanes", last_rsp, {18'h00922, 18'h00500, 18'h00311, 18'h00133});
    drain();

    // Contention from reset: grants alternate starting at req0, one rsp per cycle.
    do_reset();
    acc_ids.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_data = rand_batch();
      req1_data = rand_batch();
      step();
      if (i >= 2) check_eq("contend_rsp_per_cycle", W'(popped), W'(1));
    end
    drain();
    check_eq("contend_accepts", W'(acc_ids.size()), W'(8));
    for (int k = 0; k < acc_ids.size(); k++) check_eq("contend_order", W'(acc_ids[k]), W'(k % 2));

    // Backpressure: two batches held, then readys drop until rsp_ready returns.
    acc_ids.delete();
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_data = rand_batch();
      step();
    end
    check_eq("bp_accepts", W'(acc_ids.size()), W'(2));
    #1;
    check_eq("bp_req0_ready", W'(req0_ready), W'(0));
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_data = rand_batch();
      step();
    end
    check_eq("bp_resume_accepts", W'(acc_ids.size()), W'(8));
    drain();

    // Duplicate keys keep their low bits.
    req1_data  = {18'h00704, 18'h00203, 18'h00702, 18'h00701};
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
    check_eq("dup_lane0", W'(last_rsp[DSIZE-1:0]), W'(18'h00203));
    drain();

    // Pointer hold: req1 served last, so req0 wins once the stall clears.
    acc_ids.delete();
    rsp_ready  = 1'b0;
    req1_valid = 1'b1;
    req1_data  = rand_batch();
    step();
    req1_data  = rand_batch();
    step();
    req0_valid = 1'b1;
    req0_data  = rand_batch();
    req1_data  = rand_batch();
    step();
    rsp_ready = 1'b1;
    step();
    req0_data = rand_batch();
    step();
    drain();
    check_eq("ptr_accepts", W'(acc_ids.size()), W'(4));
    for (int k = 0; k < acc_ids.size() && k < 4; k++)
      check_eq("ptr_order", W'(acc_ids[k]), W'((k == 2) ? 0 : 1));

    // Reset with S1 and S2 both full.
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    req0_data  = rand_batch();
    step();
    req0_data  = rand_batch();
    step();
    req1_valid = 1'b1;
    req1_data  = rand_batch();
    do_reset();
    acc_ids.delete();
    rsp_ready = 1'b1;
    req0_data = rand_batch();
    req1_data = rand_batch();
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("post_rst_first_grant", W'((acc_ids.size() == 1) ? acc_ids[0] : -1), W'(0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
